uart_bank_loader: RTL and testbench
===================================

Name: uart_bank_loader

Overview:
- Parametrised successor to the single-pair UART memory loader.
- Receives a byte stream from an external uart_rx and assembles little-endian words of BYTES_PER_WORD bytes. Words are stored sequentially into NUM_BANKS internal banks of DEPTH words each.
- Exposes a random-access read port to the compute datapath (knapsack value/weight tables).
- On request, dumps all banks back through an external uart_tx. The dump is paced by the tx handshake, not a fixed timer.
- Adds a receive timeout with resync and a restart-load command.

Parameters:
BYTES_PER_WORD, 4, bytes per stored word; WIDTH = 8*BYTES_PER_WORD
DEPTH, 64, words per bank
NUM_BANKS, 2, number of banks (bank 0 filled first)
ADDR_W, 6, word-address width; must satisfy 2^ADDR_W >= DEPTH
BANK_W, 1, bank-index width; must satisfy 2^BANK_W >= NUM_BANKS
RX_TIMEOUT, 208340, idle clocks after which a partial word is discarded (20 bit-times at 9600 baud, 100 MHz)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
rx_dv  in  1  one-cycle strobe from uart_rx, byte valid
rx_byte  in  8  received byte
tx_dv  out  1  one-cycle strobe to uart_tx, start byte
tx_byte  out  8  byte to transmit
tx_active  in  1  uart_tx busy
tx_done  in  1  one-cycle strobe from uart_tx, byte finished
dump_start  in  1  level (switch); a rising edge requests a dump
load_restart  in  1  one-cycle pulse; return to load mode
rd_bank  in  BANK_W  read-port bank select
rd_addr  in  ADDR_W  read-port word address
rd_data  out  WIDTH  combinational read data
recv_done  out  1  all banks loaded (level)
send_done  out  1  dump complete (level)
rx_err  out  1  one-cycle pulse; partial word dropped by timeout

Behaviour:
Reset:
- State = LOAD; bank, addr, byte counter and idle counter = 0.
- recv_done = send_done = tx_dv = rx_err = 0; tx_byte = 0.
- The dump_start edge register is loaded with the current dump_start, so a switch already high at reset does not trigger a dump.
- Memory contents are not cleared.
- rst mid-load or mid-dump aborts immediately; tx_dv is low on the next cycle.

States: LOAD, LOADED, DUMP_ISSUE, DUMP_WAIT, DONE.

LOAD:
- On rx_dv, byte k (k = byte counter) goes to assembler bits [8k+7:8k].
- When k == BYTES_PER_WORD-1, the same cycle:
  - writes {rx_byte, assembler[8k-1:0]} to mem[bank][addr]; visible on rd_data the next cycle;
  - clears k;
  - advances addr; at addr == DEPTH-1, addr wraps to 0 and bank increments.
- The write of bank NUM_BANKS-1, addr DEPTH-1 moves to LOADED; recv_done = 1 the next cycle; counters return to 0.
- Total load length = NUM_BANKS*DEPTH*BYTES_PER_WORD bytes.

Timeout:
- The idle counter clears on every rx_dv and counts otherwise, in LOAD only.
- If k != 0 and the counter reaches RX_TIMEOUT-1: k = 0, rx_err pulses for 1 cycle, addr/bank are unchanged, and the partial bytes are lost.
- No timeout action when k == 0.

Ignored inputs:
- rx_dv is ignored outside LOAD.
- A dump_start rising edge is ignored in LOAD, DUMP_ISSUE and DUMP_WAIT.

LOADED or DONE:
- dump_start rising edge → DUMP_ISSUE with counters 0 and send_done cleared.
- load_restart → LOAD with recv_done and send_done cleared.
- load_restart takes priority over a simultaneous dump edge.

DUMP_ISSUE:
- Waits while tx_active = 1.
- When tx_active = 0: tx_byte = byte k of mem[bank][addr], tx_dv = 1 for exactly one cycle, → DUMP_WAIT.

DUMP_WAIT:
- On tx_done, advance k/addr/bank in the same order as load.
- After the last byte → DONE; send_done = 1 the next cycle. Otherwise → DUMP_ISSUE.
- Byte order on the wire is identical to the load order.

Read port:
- rd_data = mem[rd_bank][rd_addr], combinational, valid in every state.
- rd_bank >= NUM_BANKS or rd_addr >= DEPTH returns 0.
- A read of the location being written in the same cycle returns the old value.

Test Plan:
Bench params: BYTES_PER_WORD=4, DEPTH=4, NUM_BANKS=2, RX_TIMEOUT=50; uart_tx modelled with a 30-cycle busy per byte.
1. Full load:
   - Stimulus: send bytes 0x00..0x1F, one rx_dv every 10 cycles.
   - Required: rd(0,0) = 0x03020100; rd(0,3) = 0x0F0E0D0C; rd(1,0) = 0x13121110; rd(1,3) = 0x1F1E1D1C; recv_done rises 1 cycle after the 32nd rx_dv; rd(2,0) = 0.
2. Timeout resync:
   - Stimulus: send 0xAA, 0xBB, then 60 idle cycles, then 0x01..0x04.
   - Required: rx_err pulses once; rd(0,0) = 0x04030201; rx_err never pulses when idle with k == 0.
3. Dump:
   - Stimulus: after case 1, raise dump_start.
   - Required: 32 tx_dv pulses, each only while tx_active = 0, tx_byte sequence 0x00..0x1F; send_done = 1 after the final tx_done; a further rx_dv does not change memory.
4. Switch held high through reset:
   - Stimulus: dump_start = 1 during and after reset, then complete a load.
   - Required: no dump occurs until dump_start toggles 0→1.
5. Restart and re-dump:
   - Stimulus: load_restart in DONE, then load bytes 0x40..0x5F, then toggle dump_start.
   - Required: recv_done/send_done clear on restart; rd(1,3) = 0x5F5E5D5C; dump emits 0x40..0x5F.
6. Reset mid-dump:
   - Stimulus: assert rst after the 5th tx_dv.
   - Required: no further tx_dv; state LOAD, recv_done = 0; rd(0,0) retains 0x03020100.

Source files
------------

// File: rtl/uart_bank_loader.sv
// UART byte-stream loader: packs little-endian words into banked memory,
// serves a random-access read port and dumps the banks back over uart_tx.
module uart_bank_loader #(
  parameter int BYTES_PER_WORD = 4,
  parameter int DEPTH          = 64,
  parameter int NUM_BANKS      = 2,
  parameter int ADDR_W         = 6,
  parameter int BANK_W         = 1,
  parameter int RX_TIMEOUT     = 208340,
  localparam int WIDTH         = 8 * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [7:0]        rx_byte,
  output logic              tx_dv,
  output logic [7:0]        tx_byte,
  input  logic              tx_active,
  input  logic              tx_done,
  input  logic              dump_start,
  input  logic              load_restart,
  input  logic [BANK_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              recv_done,
  output logic              send_done,
  output logic              rx_err
);

  localparam int N     = NUM_BANKS * DEPTH;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int KW    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int IW    = $clog2(RX_TIMEOUT + 1);
  localparam int AW    = (BYTES_PER_WORD > 1) ? WIDTH - 8 : 8;

  typedef enum logic [2:0] {
    LOAD, LOADED, DUMP_ISSUE, DUMP_WAIT, DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]  mem [N];
  logic [KW-1:0]     k, k_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [BANK_W-1:0] bank, bank_n;
  logic [IW-1:0]     idle;
  logic [AW-1:0]     asm_q;
  logic              dump_q;

  logic k_last, a_last, b_last, last_word, dump_edge;
  logic wr, tmo, fire, step, adv;
  logic [WIDTH-1:0] wdata, cur;
  logic [7:0]       sel;
  logic             rd_ok;

  function automatic logic [IDX_W-1:0] idx(
    input logic [BANK_W-1:0] b,
    input logic [ADDR_W-1:0] a
  );
    return IDX_W'(32'(b) * DEPTH + 32'(a));
  endfunction

  assign k_last    = (k == KW'(BYTES_PER_WORD - 1));
  assign a_last    = (addr == ADDR_W'(DEPTH - 1));
  assign b_last    = (bank == BANK_W'(NUM_BANKS - 1));
  assign last_word = k_last & a_last & b_last;
  assign dump_edge = dump_start & ~dump_q;

  // out-of-range reads return zero instead of aliasing
  assign rd_ok   = (32'(rd_bank) < NUM_BANKS) && (32'(rd_addr) < DEPTH);
  assign rd_data = rd_ok ? mem[idx(rd_bank, rd_addr)] : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      LOAD:
        if (wr && a_last && b_last) state_n = LOADED;
      LOADED, DONE:
        if (load_restart)   state_n = LOAD;
        else if (dump_edge) state_n = DUMP_ISSUE;
      DUMP_ISSUE:
        if (fire) state_n = DUMP_WAIT;
      DUMP_WAIT:
        if (step) state_n = last_word ? DONE : DUMP_ISSUE;
      default:
        state_n = LOAD;
    endcase
  end

  always_comb begin
    wr   = 1'b0;
    tmo  = 1'b0;
    fire = 1'b0;
    step = 1'b0;
    adv  = 1'b0;
    unique case (state)
      LOAD: begin
        wr  = rx_dv & k_last;
        adv = rx_dv;
        tmo = ~rx_dv && (k != '0) &&
              (idle == IW'(RX_TIMEOUT - 1));
      end
      DUMP_ISSUE: fire = ~tx_active;
      DUMP_WAIT: begin
        step = tx_done;
        adv  = tx_done;
      end
      default: ;
    endcase
  end

  // byte -> word -> bank walk shared by load and dump
  always_comb begin
    k_n    = k + 1'b1;
    addr_n = addr;
    bank_n = bank;
    if (k_last) begin
      k_n = '0;
      if (a_last) begin
        addr_n = '0;
        bank_n = b_last ? '0 : bank + 1'b1;
      end else begin
        addr_n = addr + 1'b1;
      end
    end
  end

  always_comb begin
    wdata = WIDTH'(asm_q);
    wdata[WIDTH-1 -: 8] = rx_byte;
    cur = mem[idx(bank, addr)];
    sel = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++)
      if (k == KW'(i)) sel = cur[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[idx(bank, addr)] <= wdata;
  end

  always_ff @(posedge clk) begin
    dump_q <= dump_start;
    if (rst) begin
      k         <= '0;
      addr      <= '0;
      bank      <= '0;
      idle      <= '0;
      asm_q     <= '0;
      recv_done <= 1'b0;
      send_done <= 1'b0;
      tx_dv     <= 1'b0;
      tx_byte   <= '0;
      rx_err    <= 1'b0;
    end else begin
      tx_dv  <= 1'b0;
      rx_err <= 1'b0;
      if (adv) begin
        k    <= k_n;
        addr <= addr_n;
        bank <= bank_n;
      end
      if (state == LOAD) begin
        if (rx_dv)
          for (int i = 0; i < BYTES_PER_WORD - 1; i++)
            if (k == KW'(i)) asm_q[8*i +: 8] <= rx_byte;
        if (rx_dv || tmo)
          idle <= '0;
        else if (idle != IW'(RX_TIMEOUT - 1))
          idle <= idle + 1'b1;
      end
      if (tmo) begin
        k      <= '0;
        rx_err <= 1'b1;
      end
      if (wr && a_last && b_last) recv_done <= 1'b1;
      if (fire) begin
        tx_dv   <= 1'b1;
        tx_byte <= sel;
      end
      if (step && last_word) send_done <= 1'b1;
      if (state == LOADED || state == DONE) begin
        if (load_restart) begin
          recv_done <= 1'b0;
          send_done <= 1'b0;
          idle      <= '0;
          k         <= '0;
          addr      <= '0;
          bank      <= '0;
        end else if (dump_edge) begin
          send_done <= 1'b0;
          k         <= '0;
          addr      <= '0;
          bank      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_bank_loader.sv
// Directed bench for uart_bank_loader: small banks, fast timeout,
// and a uart_tx model that stays busy 30 cycles per byte.
module tb_uart_bank_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active = 1'b0;
  logic        tx_done = 1'b0;
  logic        dump_start = 1'b1;
  logic        load_restart = 1'b0;
  logic [1:0]  rd_bank = '0;
  logic [1:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        recv_done, send_done, rx_err;

  int checks = 0;
  int failures = 0;

  int         busy = 0;
  int         viol = 0;
  int         errcnt = 0;
  logic [7:0] txq [$];

  uart_bank_loader #(
    .BYTES_PER_WORD(4),
    .DEPTH(4),
    .NUM_BANKS(2),
    .ADDR_W(2),
    .BANK_W(2),
    .RX_TIMEOUT(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_dv(rx_dv),
    .rx_byte(rx_byte),
    .tx_dv(tx_dv),
    .tx_byte(tx_byte),
    .tx_active(tx_active),
    .tx_done(tx_done),
    .dump_start(dump_start),
    .load_restart(load_restart),
    .rd_bank(rd_bank),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .recv_done(recv_done),
    .send_done(send_done),
    .rx_err(rx_err)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (rx_err) errcnt <= errcnt + 1;
    if (tx_dv) begin
      txq.push_back(tx_byte);
      if (tx_active || busy > 0) viol <= viol + 1;
    end
    if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1) begin
        tx_active <= 1'b0;
        tx_done   <= 1'b1;
      end
    end else if (tx_dv) begin
      tx_active <= 1'b1;
      busy      <= 30;
    end
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rd(string tag, int b, int a, logic [31:0] exp);
    rd_bank = 2'(b);
    rd_addr = 2'(a);
    #1;
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic send(logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load(string tag, logic [7:0] base);
    for (int i = 0; i < 31; i++) send(base + 8'(i));
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = base + 8'd31;
    chk({tag, "_recv_pre"}, 64'(recv_done), 64'd0);
    @(negedge clk);
    rx_dv = 1'b0;
    chk({tag, "_recv_done"}, 64'(recv_done), 64'd1);
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_dump();
    @(negedge clk);
    dump_start = 1'b0;
    repeat (2) @(negedge clk);
    dump_start = 1'b1;
  endtask

  task automatic check_dump(string tag, int base, logic [7:0] v0);
    int n;
    n = 0;
    while (!send_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_send_done"}, 64'(send_done), 64'd1);
    chk({tag, "_count"}, 64'(txq.size() - base), 64'd32);
    for (int i = 0; i < 32; i++)
      if (base + i < txq.size())
        chk({tag, "_byte"}, 64'(txq[base + i]), 64'(v0 + 8'(i)));
    chk({tag, "_busy_viol"}, 64'(viol), 64'd0);
  endtask

  initial begin
    int base;
    int n;

    // switch high through reset
    repeat (3) @(negedge clk);
    chk("rst_recv", 64'(recv_done), 64'd0);
    chk("rst_send", 64'(send_done), 64'd0);
    chk("rst_txdv", 64'(tx_dv), 64'd0);
    chk("rst_txbyte", 64'(tx_byte), 64'd0);
    chk("rst_rxerr", 64'(rx_err), 64'd0);
    rst = 1'b0;

    // partial word dropped by timeout
    send(8'hAA);
    send(8'hBB);
    repeat (60) @(negedge clk);
    chk("tmo_err_once", 64'(errcnt), 64'd1);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    chk_rd("tmo_word", 0, 0, 32'h04030201);
    repeat (80) @(negedge clk);
    chk("tmo_idle_k0", 64'(errcnt), 64'd1);

    // full load with dump_start still high
    do_reset();
    base = txq.size();
    load("l1", 8'h00);
    chk_rd("l1_rd00", 0, 0, 32'h03020100);
    chk_rd("l1_rd03", 0, 3, 32'h0F0E0D0C);
    chk_rd("l1_rd10", 1, 0, 32'h13121110);
    chk_rd("l1_rd13", 1, 3, 32'h1F1E1D1C);
    chk_rd("l1_rd20", 2, 0, 32'h0);
    repeat (100) @(negedge clk);
    chk("held_no_dump", 64'(txq.size() - base), 64'd0);
    chk("held_send", 64'(send_done), 64'd0);

    // dump
    base = txq.size();
    pulse_dump();
    check_dump("d1", base, 8'h00);
    for (int i = 0; i < 4; i++) send(8'hEE);
    chk_rd("d1_nowr00", 0, 0, 32'h03020100);
    chk_rd("d1_nowr13", 1, 3, 32'h1F1E1D1C);
    chk("d1_recv", 64'(recv_done), 64'd1);

    // restart and re-dump
    @(negedge clk);
    load_restart = 1'b1;
    @(negedge clk);
    load_restart = 1'b0;
    chk("rs_recv_clr", 64'(recv_done), 64'd0);
    chk("rs_send_clr", 64'(send_done), 64'd0);
    load("l2", 8'h40);
    chk_rd("l2_rd13", 1, 3, 32'h5F5E5D5C);
    chk_rd("l2_rd00", 0, 0, 32'h43424140);
    base = txq.size();
    pulse_dump();
    check_dump("d2", base, 8'h40);

    // reload, then reset mid-dump
    @(negedge clk);
    load_restart = 1'b1;
    @(negedge clk);
    load_restart = 1'b0;
    load("l3", 8'h00);
    base = txq.size();
    pulse_dump();
    n = 0;
    while (txq.size() - base < 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_five", 64'(txq.size() - base), 64'd5);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_txdv_low", 64'(tx_dv), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_no_more", 64'(txq.size() - base), 64'd5);
    chk("mid_recv", 64'(recv_done), 64'd0);
    chk("mid_send", 64'(send_done), 64'd0);
    chk_rd("mid_keep", 0, 0, 32'h03020100);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    chk_rd("mid_load_mode", 0, 0, 32'h44332211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
